noc_vchannel_mux: RTL and testbench

NOC_VCHANNEL_MUX -- requirements
Module: noc_vchannel_mux

---
 rtl/noc_vchannel_mux.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_noc_vchannel_mux.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vchannel_mux.sv
// ---------------------------------------------------------------------------
// noc_vchannel_mux
//
// Purpose:
//   Multiplexes CHANNELS virtual-channel flit streams onto one physical link.
//   Packets are never interleaved. While no packet is in flight, a round-robin
//   arbiter picks the next channel. Once a multi-flit packet has started, its
//   channel owns the link until the flit marked "last" has been transferred.
//   The link side is a single output register that accepts a new flit
//   whenever it is empty or is being drained in the same cycle. This gives
//   1-cycle latency and full throughput.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_flit      per-VC flit data, VC i in bits [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last      per-VC last-flit-of-packet marker
//   in_valid     per-VC flit valid
//   in_ready     per-VC flit accepted this cycle (at most one bit set)
//   out_flit     registered link flit
//   out_last     registered last marker
//   out_channel  registered one-hot VC of out_flit
//   out_valid    out_flit valid
//   out_ready    downstream link accepts out_flit
//
// The optimsoc package below is a minimal local definition. It carries only
// the configuration fields this block uses. It lets the file elaborate on its
// own, and it has the same names as the system package.
// ---------------------------------------------------------------------------

package optimsoc;

    typedef struct packed {
        int NOC_FLIT_WIDTH;
        int NOC_VCHANNELS;
    } base_config_t;

    typedef struct packed {
        int NOC_FLIT_WIDTH;
        int NOC_VCHANNELS;
    } config_t;

    function automatic config_t derive_config(input base_config_t base);
        config_t cfg;
        cfg.NOC_FLIT_WIDTH = base.NOC_FLIT_WIDTH;
        cfg.NOC_VCHANNELS  = base.NOC_VCHANNELS;
        return cfg;
    endfunction

    localparam base_config_t DEFAULT_BASE_CONFIG = '{NOC_FLIT_WIDTH: 32, NOC_VCHANNELS: 3};
    localparam config_t      DEFAULT_CONFIG      = derive_config(DEFAULT_BASE_CONFIG);

endpackage

module noc_vchannel_mux #(
    // Instantiations are expected to pass derive_config() of the system base
    // configuration. The default exists only so the block elaborates stand-alone.
    parameter optimsoc::config_t CONFIG = optimsoc::DEFAULT_CONFIG
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [CONFIG.NOC_VCHANNELS*CONFIG.NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic [CONFIG.NOC_VCHANNELS-1:0]                       in_last,
    input  logic [CONFIG.NOC_VCHANNELS-1:0]                       in_valid,
    output logic [CONFIG.NOC_VCHANNELS-1:0]                       in_ready,
    output logic [CONFIG.NOC_FLIT_WIDTH-1:0]                      out_flit,
    output logic                                                  out_last,
    output logic [CONFIG.NOC_VCHANNELS-1:0]                       out_channel,
    output logic                                                  out_valid,
    input  logic                                                  out_ready
);

    localparam int FLIT_WIDTH = CONFIG.NOC_FLIT_WIDTH;
    localparam int CHANNELS   = CONFIG.NOC_VCHANNELS;
    localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W      = IDX_W + 1;

    localparam logic [SUM_W-1:0] CH_NUM   = SUM_W'(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Channel index to one-hot channel vector.
    function automatic logic [CHANNELS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [CHANNELS-1:0] oh;
        oh = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (idx == IDX_W'(c)) begin
                oh[c] = 1'b1;
            end else begin
                oh[c] = 1'b0;
            end
        end
        return oh;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        owner_r;
    logic [IDX_W-1:0]        prio_r;

    logic [FLIT_WIDTH-1:0]   out_flit_r;
    logic                    out_last_r;
    logic [CHANNELS-1:0]     out_channel_r;
    logic                    out_valid_r;

    logic                    rr_found_s;
    logic [IDX_W-1:0]        rr_idx_s;
    logic [SUM_W-1:0]        rr_sum_s;
    logic [IDX_W-1:0]        rr_cand_s;

    logic                    grant_valid_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic [FLIT_WIDTH-1:0]   sel_flit_s;
    logic                    sel_last_s;

    logic                    accept_s;
    logic                    transfer_s;
    logic [IDX_W-1:0]        prio_next_s;

    // The output register can take a new flit when it is empty or being drained.
    assign accept_s = !out_valid_r || out_ready;

    // Round-robin search: the first asserted in_valid, starting at prio_r and wrapping past the top channel.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        rr_sum_s   = '0;
        rr_cand_s  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_sum_s = {1'b0, prio_r} + SUM_W'(k);
            if (rr_sum_s >= CH_NUM) begin
                rr_cand_s = IDX_W'(rr_sum_s - CH_NUM);
            end else begin
                rr_cand_s = rr_sum_s[IDX_W-1:0];
            end
            if (!rr_found_s && in_valid[rr_cand_s]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_cand_s;
            end else begin
                rr_found_s = rr_found_s;
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Grant source: the arbiter winner when unlocked, otherwise only the packet owner.
    always_comb begin
        grant_idx_s   = '0;
        grant_valid_s = 1'b0;
        case (state_r)
            ST_UNLOCKED: begin
                grant_idx_s   = rr_idx_s;
                grant_valid_s = rr_found_s;
            end
            ST_LOCKED: begin
                grant_idx_s   = owner_r;
                grant_valid_s = in_valid[owner_r];
            end
            default: begin
                grant_idx_s   = '0;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // Data mux: flit and last marker of the granted channel.
    always_comb begin
        sel_flit_s = '0;
        sel_last_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_idx_s == IDX_W'(c)) begin
                sel_flit_s = in_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
                sel_last_s = in_last[c];
            end else begin
                sel_flit_s = sel_flit_s;
                sel_last_s = sel_last_s;
            end
        end
    end

    // Gating with rst_n keeps every in_ready low while reset is held.
    // in_ready is gated with the granted channel's valid, so it only rises for a real handshake.
    assign transfer_s = accept_s && grant_valid_s && rst_n;
    assign in_ready   = transfer_s ? idx_to_onehot(grant_idx_s) : '0;

    // The priority moves to the channel after the one that just finished a packet.
    always_comb begin
        if (grant_idx_s == LAST_IDX) begin
            prio_next_s = '0;
        end else begin
            prio_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Lock state: a multi-flit packet locks the link until its last flit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (transfer_s && !sel_last_s) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (transfer_s && sel_last_s) begin
                    state_next_s = ST_UNLOCKED;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_UNLOCKED;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Owner capture at packet start and round-robin pointer update at packet end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= '0;
            prio_r  <= '0;
        end else if (transfer_s) begin
            if (state_r == ST_UNLOCKED) begin
                owner_r <= grant_idx_s;
            end else begin
                owner_r <= owner_r;
            end
            if (sel_last_s) begin
                prio_r <= prio_next_s;
            end else begin
                prio_r <= prio_r;
            end
        end else begin
            owner_r <= owner_r;
            prio_r  <= prio_r;
        end
    end

    // Single-entry output register: load on a transfer, empty on an idle accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_flit_r    <= '0;
            out_channel_r <= '0;
        end else if (transfer_s) begin
            out_valid_r   <= 1'b1;
            out_last_r    <= sel_last_s;
            out_flit_r    <= sel_flit_s;
            out_channel_r <= idx_to_onehot(grant_idx_s);
        end else if (accept_s) begin
            out_valid_r   <= 1'b0;
            out_last_r    <= out_last_r;
            out_flit_r    <= out_flit_r;
            out_channel_r <= out_channel_r;
        end else begin
            out_valid_r   <= out_valid_r;
            out_last_r    <= out_last_r;
            out_flit_r    <= out_flit_r;
            out_channel_r <= out_channel_r;
        end
    end

    assign out_flit    = out_flit_r;
    assign out_last    = out_last_r;
    assign out_channel = out_channel_r;
    assign out_valid   = out_valid_r;

endmodule

// File: tb/tb_noc_vchannel_mux.sv
// ---------------------------------------------------------------------------
// tb_noc_vchannel_mux
//
// Self-checking bench for noc_vchannel_mux, configured with 3 VCs and 16-bit flits.
// Each flit carries its VC number in bits [15:14] and a per-VC counter below that.
// A behavioural model tracks lock/owner/priority and the expected output register.
// A per-VC scoreboard checks order, content and non-interleaving at the link.
// Directed sequences pin specific literal values.
// ---------------------------------------------------------------------------
module tb_noc_vchannel_mux;

    localparam optimsoc::base_config_t BASE_CFG = '{NOC_FLIT_WIDTH: 16, NOC_VCHANNELS: 3};
    localparam optimsoc::config_t      CFG      = optimsoc::derive_config(BASE_CFG);
    localparam int FW = 16;
    localparam int CH = 3;

    logic              clk;
    logic              rst_n;
    logic [CH*FW-1:0]  in_flit;
    logic [CH-1:0]     in_last;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_last;
    logic [CH-1:0]     out_channel;
    logic              out_valid;
    logic              out_ready;

    noc_vchannel_mux #(.CONFIG(CFG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit     (in_flit),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_last    (out_last),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit            m_locked;
    int            m_owner;
    int            m_prio;
    bit            m_ov;
    bit            m_ol;
    logic [FW-1:0] m_of;
    logic [CH-1:0] m_oc;
    int            m_g;
    bit            m_acc;
    logic [CH-1:0] m_hs;

    // DUT samples taken mid-cycle.
    logic [CH-1:0] s_in_ready;
    logic          s_out_valid;
    logic          s_out_last;
    logic [FW-1:0] s_out_flit;
    logic [CH-1:0] s_out_channel;

    // Scoreboard: {last, flit} per VC, in input-handshake order.
    logic [FW:0]   sb_q [CH][$];
    int            open_vc;
    int            pops;

    // Stimulus generators.
    bit            use_gen;
    bit            gen_active [CH];
    int            gen_left [CH];
    logic [13:0]   gen_cnt [CH];
    int            p_valid;
    int            fixed_len;
    bit            draining;
    bit            log_en;
    int            ord_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_locked) begin
            return in_valid[m_owner] ? m_owner : -1;
        end
        for (int k = 0; k < CH; k++) begin
            if (in_valid[(m_prio + k) % CH]) return (m_prio + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_prio = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_of = '0; m_oc = '0;
        open_vc = -1; pops = 0;
        for (int v = 0; v < CH; v++) begin
            sb_q[v].delete();
            gen_active[v] = 1'b0;
            gen_left[v]   = 0;
        end
    endtask

    task automatic sb_consume();
        int vc;
        logic [FW:0] exp_e;
        vc = int'(s_out_flit[FW-1:FW-2]);
        if (vc >= CH) begin
            checks++; errors++;
            $display("FAIL sb_vc: got VC %0d required below %0d", vc, CH);
        end else if (sb_q[vc].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: got flit 0x%0h required none pending on VC %0d", s_out_flit, vc);
        end else begin
            exp_e = sb_q[vc].pop_front();
            chk("sb_flit", 32'({s_out_last, s_out_flit}), 32'(exp_e));
            chk("sb_channel", 32'(s_out_channel), 32'(1 << vc));
            if (open_vc >= 0) chk("sb_no_interleave", 32'(vc), 32'(open_vc));
            open_vc = s_out_last ? -1 : vc;
            pops++;
        end
    endtask

    // Mid-cycle compare of DUT against the model for the current inputs.
    task automatic check_cycle();
        s_in_ready    = in_ready;
        s_out_valid   = out_valid;
        s_out_last    = out_last;
        s_out_flit    = out_flit;
        s_out_channel = out_channel;
        m_acc = !m_ov || out_ready;
        m_g   = model_grant();
        m_hs  = '0;
        if (m_acc && m_g >= 0) m_hs[m_g] = 1'b1;
        chk("handshake", 32'(s_in_ready & in_valid), 32'(m_hs));
        chk("ready_onehot", 32'($countones(s_in_ready) <= 1), 32'(1));
        chk("out_valid", 32'(s_out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_flit", 32'(s_out_flit), 32'(m_of));
            chk("out_last", 32'(s_out_last), 32'(m_ol));
            chk("out_channel", 32'(s_out_channel), 32'(m_oc));
        end
        if (s_out_valid && out_ready) begin
            if (log_en) begin
                for (int c = 0; c < CH; c++) if (s_out_channel[c]) ord_log.push_back(c);
            end
            sb_consume();
        end
    endtask

    // Model step for the rising edge just taken.
    task automatic model_update();
        if (m_acc) begin
            if (m_g >= 0) begin
                m_ov = 1'b1;
                m_of = in_flit[m_g*FW +: FW];
                m_ol = in_last[m_g];
                m_oc = CH'(1) << m_g;
                sb_q[m_g].push_back({in_last[m_g], in_flit[m_g*FW +: FW]});
                if (!m_locked && !in_last[m_g]) begin
                    m_locked = 1'b1;
                    m_owner  = m_g;
                end else if (m_locked && in_last[m_g]) begin
                    m_locked = 1'b0;
                end
                if (in_last[m_g]) m_prio = (m_g + 1) % CH;
                if (use_gen) begin
                    gen_cnt[m_g]    = gen_cnt[m_g] + 14'd1;
                    gen_left[m_g]   = gen_left[m_g] - 1;
                    gen_active[m_g] = 1'b0;
                end
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_vc(input int v, input bit val, input bit last, input logic [FW-1:0] f);
        in_valid[v] = val;
        in_last[v]  = last;
        in_flit[v*FW +: FW] = f;
    endtask

    task automatic drive_gen();
        for (int v = 0; v < CH; v++) begin
            if (!gen_active[v]) begin
                if (gen_left[v] == 0) begin
                    if (!draining && $urandom_range(99) < p_valid) begin
                        gen_left[v]   = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
                        gen_active[v] = 1'b1;
                    end
                end else if (draining || $urandom_range(99) < p_valid) begin
                    gen_active[v] = 1'b1;
                end
            end
            in_valid[v] = gen_active[v];
            in_last[v]  = (gen_left[v] == 1);
            in_flit[v*FW +: FW] = {2'(v), gen_cnt[v]};
        end
    endtask

    task automatic run_gen(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            drive_gen();
            out_ready = ($urandom_range(99) < ready_pct);
            tick();
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        draining = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            drive_gen();
            out_ready = 1'b1;
            tick();
            done = !m_ov;
            for (int v = 0; v < CH; v++) if (gen_left[v] != 0 || gen_active[v]) done = 1'b0;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got traffic still pending required idle within 300 cycles");
        end
        for (int v = 0; v < CH; v++) chk("sb_empty", 32'(sb_q[v].size()), 32'(0));
        draining = 1'b0;
        in_valid = '0;
    endtask

    // Entered at a falling edge; releases reset at a falling edge.
    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '1;
        in_last   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_out_flit", 32'(out_flit), 32'(0));
        chk("rst_out_channel", 32'(out_channel), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        model_reset();
        repeat (2) @(negedge clk);
        in_valid = '0;
        in_last  = '0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord [8];
        exp_ord = '{0, 0, 1, 1, 2, 2, 0, 0};
        rst_n = 1'b0; in_flit = '0; in_last = '0; in_valid = '0; out_ready = 1'b1;
        use_gen = 1'b0; p_valid = 0; fixed_len = 0; draining = 1'b0; log_en = 1'b0;
        for (int v = 0; v < CH; v++) gen_cnt[v] = '0;
        model_reset();
        @(negedge clk);

        // VC1 3-flit packet: one-hot 010 for three cycles, last only on the third.
        apply_reset();
        set_vc(1, 1'b1, 1'b0, 16'h4001); tick();
        chk("p1_ready", 32'(s_in_ready), 32'(3'b010));
        set_vc(1, 1'b1, 1'b0, 16'h4002); tick();
        chk("p1_ch_a", 32'(s_out_channel), 32'(3'b010));
        chk("p1_last_a", 32'(s_out_last), 32'(0));
        chk("p1_flit_a", 32'(s_out_flit), 32'(16'h4001));
        set_vc(1, 1'b1, 1'b1, 16'h4003); tick();
        chk("p1_ch_b", 32'(s_out_channel), 32'(3'b010));
        chk("p1_last_b", 32'(s_out_last), 32'(0));
        set_vc(1, 1'b0, 1'b0, 16'h4003); tick();
        chk("p1_ch_c", 32'(s_out_channel), 32'(3'b010));
        chk("p1_last_c", 32'(s_out_last), 32'(1));
        chk("p1_flit_c", 32'(s_out_flit), 32'(16'h4003));
        tick();
        chk("p1_idle", 32'(s_out_valid), 32'(0));
        chk("model_prio_pin", 32'(m_prio), 32'(2));

        // All VCs continuously offering 2-flit packets.
        apply_reset();
        use_gen = 1'b1; p_valid = 100; fixed_len = 2;
        ord_log.delete(); log_en = 1'b1;
        run_gen(20, 100);
        log_en = 1'b0;
        chk("p2_count", 32'(ord_log.size() >= 8), 32'(1));
        for (int i = 0; i < 8 && i < ord_log.size(); i++) chk("p2_order", 32'(ord_log[i]), 32'(exp_ord[i]));
        drain();
        use_gen = 1'b0; fixed_len = 0;

        // VC0 locked with a 2-cycle bubble while VC2 waits.
        apply_reset();
        set_vc(0, 1'b1, 1'b0, 16'h0010); set_vc(2, 1'b1, 1'b1, 16'h8020); tick();
        chk("p3_grant0", 32'(s_in_ready), 32'(3'b001));
        chk("model_lock_pin", 32'(m_locked), 32'(1));
        set_vc(0, 1'b0, 1'b0, 16'h0011); tick();
        chk("p3_bubble_a", 32'(s_in_ready), 32'(3'b000));
        tick();
        chk("p3_bubble_b", 32'(s_in_ready), 32'(3'b000));
        set_vc(0, 1'b1, 1'b1, 16'h0011); tick();
        chk("p3_resume0", 32'(s_in_ready), 32'(3'b001));
        set_vc(0, 1'b0, 1'b0, 16'h0011); tick();
        chk("p3_grant2", 32'(s_in_ready), 32'(3'b100));
        chk("p3_out_vc0", 32'(s_out_flit), 32'(16'h0011));
        set_vc(2, 1'b0, 1'b0, 16'h8020); tick(); tick();

        // Backpressure for 4 cycles mid-packet.
        apply_reset();
        set_vc(1, 1'b1, 1'b0, 16'h4101); tick();
        set_vc(1, 1'b1, 1'b0, 16'h4102); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("p4_ready_low", 32'(s_in_ready), 32'(0));
            chk("p4_flit_hold", 32'(s_out_flit), 32'(16'h4101));
            chk("p4_valid_hold", 32'(s_out_valid), 32'(1));
        end
        out_ready = 1'b1; tick();
        set_vc(1, 1'b1, 1'b0, 16'h4103); tick();
        set_vc(1, 1'b1, 1'b1, 16'h4104); tick();
        set_vc(1, 1'b0, 1'b0, 16'h4104); tick(); tick();
        chk("p4_delivered", 32'(pops), 32'(4));
        chk("p4_sb_empty", 32'(sb_q[1].size()), 32'(0));

        // Reset after the second flit of a VC2 packet; VC0 wins afterwards.
        apply_reset();
        set_vc(2, 1'b1, 1'b0, 16'h8201); tick();
        set_vc(2, 1'b1, 1'b0, 16'h8202); tick();
        chk("p5_pre_valid", 32'(s_out_valid), 32'(1));
        apply_reset();
        set_vc(0, 1'b1, 1'b1, 16'h0301); set_vc(2, 1'b1, 1'b1, 16'h8301); tick();
        chk("p5_first_vc0", 32'(s_in_ready), 32'(3'b001));
        set_vc(0, 1'b0, 1'b0, 16'h0301); tick();
        chk("p5_then_vc2", 32'(s_in_ready), 32'(3'b100));
        chk("p5_out_ch", 32'(s_out_channel), 32'(3'b001));
        set_vc(2, 1'b0, 1'b0, 16'h8301); tick(); tick();

        // Random traffic, random backpressure.
        apply_reset();
        use_gen = 1'b1; fixed_len = 0;
        for (int blk = 0; blk < 20; blk++) begin
            p_valid = int'($urandom_range(20, 90));
            run_gen(500, int'($urandom_range(30, 100)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
